pe_dc_seq: RTL and testbench
============================

Name: pe_dc_seq

Overview:
- Channel-folded, multi-kernel successor of the binary deconvolution PE.
- Accepts one FH×FW×D binary window as N_BEATS = D/DP beats of DP channels each, and accumulates the XNOR-popcount for N_KERNEL kernels in parallel.
- After the last beat, each kernel's sum goes through batch-norm thresholding, sign flip and unpooling demux, and the result is held in an output register under valid/ready handshake.
- Sits between the line-buffer/window generator and the unpooled feature-map writer in the decoder path.

Parameters:
- D, 512: input channels per window.
- DP, 64: channels consumed per beat; D % DP == 0 is required (elaboration error otherwise).
- FH, 3: filter height.
- FW, 3: filter width.
- N_KERNEL, 4: kernels (output channels) computed in parallel.
- POOL_H, 2: unpool height.
- POOL_W, 2: unpool width.
- Derived: N_BEATS = D/DP.
- Derived: BEAT_W = DP*FH*FW.
- Derived: ACC_W = clog2(D*FH*FW+1).
- Derived: NREF_W = ACC_W+1.
- Derived: PIDX_W = max(clog2(POOL_H*POOL_W),1).
- Derived: OUT_W = POOL_H*POOL_W.

Ports:
- clk, in, 1: clock, rising edge.
- rst, in, 1: synchronous, active-high reset.
- in_valid, in, 1: beat valid.
- in_ready, out, 1: beat accepted when in_valid && in_ready.
- data_in, in, BEAT_W: activation bits for current DP channels.
- weight_in, in, N_KERNEL*BEAT_W: weights; kernel k occupies slice k.
- norm_ref, in, N_KERNEL*NREF_W: per-kernel thresholds; sampled on the last beat.
- s, in, N_KERNEL: per-kernel sign-flip bits; sampled on the last beat.
- pindex, in, PIDX_W: unpool position; sampled on the last beat.
- out_valid, out, 1: result valid.
- out_ready, in, 1: downstream accepts the result.
- data_out, out, N_KERNEL*OUT_W: per-kernel unpooled bits; kernel k occupies slice k.
- busy, out, 1: high while beat_cnt != 0.

Behaviour:
- Reset: beat_cnt=0, all accumulators=0, out_valid=0, data_out=0, busy=0.
- Reset mid-window discards partial sums. The next accepted beat is beat 0.
- in_ready = !(out_valid && !out_ready). It is combinational and holds even during non-last beats, to keep the rule uniform.
- Beat acceptance:
  - Per kernel: pc_k = popcount(XNOR(data_in, weight_k)), range 0..BEAT_W.
  - Beat 0: acc_k <= pc_k, overwriting (no separate clear cycle).
  - Other beats: acc_k <= acc_k + pc_k.
  - beat_cnt increments and wraps to 0 after beat N_BEATS-1.
- Last beat (beat_cnt == N_BEATS-1), combinational:
  - sum_k = acc_k + pc_k, exact in ACC_W bits with no saturation; the maximum is D*FH*FW.
  - bin_k = ({sum_k,1'b0} >= norm_ref_k) XOR s_k. This is an unsigned comparison with one fractional bit on the sum.
- Output register update on the last beat:
  - data_out slice k <= bin_k placed at bit pindex; all other bits of the slice are 0.
  - If POOL_H*POOL_W == 1, slice k = bin_k and pindex is ignored.
  - If pindex >= OUT_W, all slice bits are 0.
  - out_valid <= 1.
- Latency: result visible the cycle after the last beat is accepted. With out_ready held high, throughput is one window per N_BEATS cycles with zero bubbles.
- out_valid clears on out_valid && out_ready unless a new last beat is accepted in the same cycle; the last-beat write has priority and out_valid stays 1.
- Output stability: data_out holds while out_valid && !out_ready. Input stalls freeze beat_cnt and the accumulators.
- in_valid gaps between beats are legal. Partial sums are retained indefinitely.

Decomposition:
- Package pe_dc_pkg holds:
  - clog2-derived width functions (ACC_W, NREF_W, PIDX_W);
  - default geometry constants;
  - the function popcount_xnor(width).
- Sub-module pe_dc_lane, instantiated N_KERNEL times, contains:
  - the popcount tree;
  - the accumulator;
  - the threshold/sign compare.
- The top level owns beat_cnt, the handshake and the unpool demux.

Test Plan:
- Config D=8, DP=4, FH=FW=3, N_KERNEL=2 (BEAT_W=36, ACC_W=7, NREF_W=8), out_ready=1 unless stated.
- All-ones data and weights over 2 beats, norm_ref=144 for both kernels, s=0, pindex=2 -> sum 72, out_valid one cycle after beat 1, each kernel slice = 4'b0100. Repeat with norm_ref=145 -> slices = 4'b0000.
- Kernel 0 weights = ~data (sum 0), norm_ref0=1, s0=1; kernel 1 sum 36 with norm_ref1=72, s1=0; pindex=3 -> data_out = {4'b1000, 4'b1000}.
- Back-pressure: out_ready=0 after the first result, second window streamed -> in_ready drops, data_out unchanged, beat_cnt frozen. Raise out_ready -> first result handed over, second follows with correct values, nothing lost.
- rst pulsed after beat 0 of a window with all-ones beat 0 -> next two beats of all-zero-match data (sum 0) give bin=0 with norm_ref=1, s=0, proving no stale partial sum.
- Back-to-back windows with a 3-cycle in_valid gap between beats 0 and 1 -> results are identical to the gapless run.
- POOL_H=POOL_W=1 build, sum 40 vs norm_ref=80, s=0 -> data_out = 2'b11; pindex is ignored.

Source files
------------

// File: rtl/pe_dc_pkg.sv
// Shared geometry defaults, derived-width helpers and the XNOR-popcount
// primitive used by every kernel lane of pe_dc_seq.
package pe_dc_pkg;

  localparam int DEF_D        = 512;
  localparam int DEF_DP       = 64;
  localparam int DEF_FH       = 3;
  localparam int DEF_FW       = 3;
  localparam int DEF_N_KERNEL = 4;
  localparam int DEF_POOL_H   = 2;
  localparam int DEF_POOL_W   = 2;

  // Widest beat the popcount helper can take; lanes zero-extend up to it.
  localparam int POP_MAX_W = 1024;

  function automatic int acc_width(input int d, input int fh, input int fw);
    return $clog2(d * fh * fw + 1);
  endfunction

  function automatic int nref_width(input int d, input int fh, input int fw);
    return acc_width(d, fh, fw) + 1;
  endfunction

  function automatic int pidx_width(input int ph, input int pw);
    return (ph * pw > 1) ? $clog2(ph * pw) : 1;
  endfunction

  // Counts agreeing bit positions among the low 'width' bits of a and b.
  function automatic int popcount_xnor(input logic [POP_MAX_W-1:0] a,
                                       input logic [POP_MAX_W-1:0] b,
                                       input int width);
    int cnt;
    cnt = 0;
    for (int i = 0; i < POP_MAX_W; i++) begin
      if (i < width && a[i] == b[i]) cnt = cnt + 1;
    end
    return cnt;
  endfunction

endpackage

// File: rtl/pe_dc_lane.sv
// One kernel lane: XNOR-popcount of the current beat, window accumulator,
// and the batch-norm threshold with sign flip on the running sum.
module pe_dc_lane
  import pe_dc_pkg::*;
#(
  parameter int BEAT_W = 36,
  parameter int ACC_W  = 7,
  parameter int NREF_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              accept,
  input  logic              first,
  input  logic [BEAT_W-1:0] data,
  input  logic [BEAT_W-1:0] weight,
  input  logic [NREF_W-1:0] norm_ref,
  input  logic              sign,
  output logic              bin
);

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] pc;
  logic [ACC_W-1:0] sum;

  assign pc  = ACC_W'(popcount_xnor(POP_MAX_W'(data), POP_MAX_W'(weight), BEAT_W));
  assign sum = acc + pc;

  // The appended zero gives the sum one fractional bit so half-step
  // thresholds from batch-norm folding compare exactly.
  assign bin = ({sum, 1'b0} >= norm_ref) ^ sign;

  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
    end else if (accept) begin
      acc <= first ? pc : sum;
    end
  end

endmodule

// File: rtl/pe_dc_seq.sv
// Channel-folded binary deconvolution PE: accumulates N_BEATS beats per
// window for N_KERNEL kernels, thresholds, and unpools into a held result.
module pe_dc_seq
  import pe_dc_pkg::*;
#(
  parameter int D        = DEF_D,
  parameter int DP       = DEF_DP,
  parameter int FH       = DEF_FH,
  parameter int FW       = DEF_FW,
  parameter int N_KERNEL = DEF_N_KERNEL,
  parameter int POOL_H   = DEF_POOL_H,
  parameter int POOL_W   = DEF_POOL_W,
  localparam int N_BEATS = D / DP,
  localparam int BEAT_W  = DP * FH * FW,
  localparam int ACC_W   = acc_width(D, FH, FW),
  localparam int NREF_W  = nref_width(D, FH, FW),
  localparam int PIDX_W  = pidx_width(POOL_H, POOL_W),
  localparam int OUT_W   = POOL_H * POOL_W
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [BEAT_W-1:0]            data_in,
  input  logic [N_KERNEL*BEAT_W-1:0]   weight_in,
  input  logic [N_KERNEL*NREF_W-1:0]   norm_ref,
  input  logic [N_KERNEL-1:0]          s,
  input  logic [PIDX_W-1:0]            pindex,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [N_KERNEL*OUT_W-1:0]    data_out,
  output logic                         busy
);

  localparam int CNT_W = (N_BEATS > 1) ? $clog2(N_BEATS) : 1;

  if (D % DP != 0) begin : g_bad_dp
    $error("pe_dc_seq: D must be a multiple of DP");
  end
  if (BEAT_W > POP_MAX_W) begin : g_bad_beat
    $error("pe_dc_seq: beat wider than popcount helper");
  end

  logic [CNT_W-1:0]          beat_cnt;
  logic                      accept;
  logic                      first_beat;
  logic                      last_beat;
  logic [N_KERNEL-1:0]       bin;
  logic [N_KERNEL*OUT_W-1:0] demux;

  // Handshake: a beat transfers on in_valid && in_ready, a result on
  // out_valid && out_ready. Inputs stall whenever a held result is not
  // being taken, on every beat, so the last beat can never overwrite it.
  assign in_ready   = !(out_valid && !out_ready);
  assign accept     = in_valid && in_ready;
  assign first_beat = (beat_cnt == '0);
  assign last_beat  = (beat_cnt == CNT_W'(N_BEATS - 1));
  assign busy       = (beat_cnt != '0);

  for (genvar k = 0; k < N_KERNEL; k++) begin : g_lane
    pe_dc_lane #(
      .BEAT_W (BEAT_W),
      .ACC_W  (ACC_W),
      .NREF_W (NREF_W)
    ) u_lane (
      .clk      (clk),
      .rst      (rst),
      .accept   (accept),
      .first    (first_beat),
      .data     (data_in),
      .weight   (weight_in[k*BEAT_W +: BEAT_W]),
      .norm_ref (norm_ref[k*NREF_W +: NREF_W]),
      .sign     (s[k]),
      .bin      (bin[k])
    );

    if (OUT_W == 1) begin : g_nopool
      logic unused_pindex;
      assign unused_pindex = ^pindex;
      assign demux[k]      = bin[k];
    end else begin : g_pool
      // Shifting past the slice width naturally yields an all-zero slice.
      assign demux[k*OUT_W +: OUT_W] = OUT_W'(bin[k]) << pindex;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      beat_cnt  <= '0;
      out_valid <= 1'b0;
      data_out  <= '0;
    end else begin
      if (accept) begin
        beat_cnt <= last_beat ? '0 : beat_cnt + CNT_W'(1);
      end
      if (accept && last_beat) begin
        data_out  <= demux;
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pe_dc_seq.sv
// Bench for pe_dc_seq: a 2x2-unpool instance and a 1x1-unpool instance on
// shared stimulus, checked against a popcount/threshold reference model.
module tb_pe_dc_seq;

  localparam int D       = 8;
  localparam int DP      = 4;
  localparam int FH      = 3;
  localparam int FW      = 3;
  localparam int NK      = 2;
  localparam int N_BEATS = D / DP;
  localparam int BEAT_W  = DP * FH * FW;
  localparam int NREF_W  = 8;
  localparam int OUT_W   = 4;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   in_valid;
  logic                   out_ready;
  logic [BEAT_W-1:0]      data_in;
  logic [NK*BEAT_W-1:0]   weight_in;
  logic [NK*NREF_W-1:0]   norm_ref;
  logic [NK-1:0]          s;
  logic [1:0]             pindex;
  logic                   pindex1;
  logic                   in_ready, out_valid, busy;
  logic [NK*OUT_W-1:0]    data_out;
  logic                   in_ready1, out_valid1, busy1;
  logic [NK-1:0]          data_out1;

  // clock/reset block
  always #5 clk = ~clk;

  int cycle = 0;
  always @(posedge clk) cycle++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  pe_dc_seq #(.D(D), .DP(DP), .FH(FH), .FW(FW), .N_KERNEL(NK),
              .POOL_H(2), .POOL_W(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .data_in(data_in), .weight_in(weight_in), .norm_ref(norm_ref), .s(s),
    .pindex(pindex), .out_valid(out_valid), .out_ready(out_ready),
    .data_out(data_out), .busy(busy)
  );

  pe_dc_seq #(.D(D), .DP(DP), .FH(FH), .FW(FW), .N_KERNEL(NK),
              .POOL_H(1), .POOL_W(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
    .data_in(data_in), .weight_in(weight_in), .norm_ref(norm_ref), .s(s),
    .pindex(pindex1), .out_valid(out_valid1), .out_ready(out_ready),
    .data_out(data_out1), .busy(busy1)
  );

  // current window and scoreboard
  logic [BEAT_W-1:0]    win_d [N_BEATS];
  logic [NK*BEAT_W-1:0] win_w [N_BEATS];
  logic [NK*NREF_W-1:0] win_nref;
  logic [NK-1:0]        win_s;
  logic [1:0]           win_pidx;
  logic [NK*OUT_W-1:0]  exp_q[$];
  logic [NK-1:0]        exp1_q[$];
  int total = 0;
  int bad   = 0;

  // reference model: whole-window agreement count, thresholded at 2*sum
  task automatic push_expected();
    logic [NK*OUT_W-1:0] e0;
    logic [NK-1:0]       e1;
    e0 = '0;
    e1 = '0;
    for (int k = 0; k < NK; k++) begin
      int   sum;
      logic b;
      sum = 0;
      for (int bt = 0; bt < N_BEATS; bt++)
        sum += $countones(~(win_d[bt] ^ win_w[bt][k*BEAT_W +: BEAT_W]));
      b = ((2 * sum) >= int'(win_nref[k*NREF_W +: NREF_W])) ^ win_s[k];
      e1[k] = b;
      if (int'(win_pidx) < OUT_W) e0[k*OUT_W + int'(win_pidx)] = b;
    end
    exp_q.push_back(e0);
    exp1_q.push_back(e1);
  endtask

  function automatic logic [BEAT_W-1:0] rand_beat();
    return BEAT_W'({$urandom(), $urandom()});
  endfunction

  task automatic randomize_window();
    for (int b = 0; b < N_BEATS; b++) begin
      win_d[b] = rand_beat();
      win_w[b] = {rand_beat(), rand_beat()};
    end
    for (int k = 0; k < NK; k++)
      win_nref[k*NREF_W +: NREF_W] = NREF_W'($urandom_range(56, 90));
    win_s    = NK'($urandom_range(0, 3));
    win_pidx = 2'($urandom_range(0, 3));
    pindex1  = 1'($urandom_range(0, 1));
  endtask

  // driver tasks
  task automatic set_beat_inputs(input int b);
    data_in   = win_d[b];
    weight_in = win_w[b];
    norm_ref  = win_nref;
    s         = win_s;
    pindex    = win_pidx;
  endtask

  task automatic drive_beat(input int b);
    int guard;
    guard = 0;
    set_beat_inputs(b);
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: in_ready=%b after %0d cycles, required 1", in_ready, guard);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_window(input int gap);
    for (int b = 0; b < N_BEATS; b++) begin
      drive_beat(b);
      if (b == 0) begin
        for (int g = 0; g < gap; g++) begin
          @(posedge clk);
          #1;
        end
      end
    end
  endtask

  // tests
  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    data_in = '0; weight_in = '0; norm_ref = '0; s = '0; pindex = '0; pindex1 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    total++;
    if (out_valid !== 1'b0 || data_out !== 8'h00 || busy !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_state: valid=%b data=%h busy=%b ready=%b, required 0 00 0 1",
               out_valid, data_out, busy, in_ready);
    end
    total++;
    if (out_valid1 !== 1'b0 || data_out1 !== 2'b00 || busy1 !== 1'b0 || in_ready1 !== 1'b1) begin
      bad++;
      $display("FAIL reset_state_pool1: valid=%b data=%b busy=%b ready=%b, required 0 00 0 1",
               out_valid1, data_out1, busy1, in_ready1);
    end
  endtask

  task automatic test_all_ones();
    logic [NREF_W-1:0]   nref_v [2];
    logic [NK*OUT_W-1:0] want   [2];
    logic [NK-1:0]       want1  [2];
    nref_v[0] = 8'd144; want[0] = 8'h44; want1[0] = 2'b11;
    nref_v[1] = 8'd145; want[1] = 8'h00; want1[1] = 2'b00;
    for (int r = 0; r < 2; r++) begin
      for (int b = 0; b < N_BEATS; b++) begin
        win_d[b] = '1;
        win_w[b] = '1;
      end
      win_nref = {nref_v[r], nref_v[r]};
      win_s    = 2'b00;
      win_pidx = 2'd2;
      drive_beat(0);
      total++;
      if (busy !== 1'b1 || out_valid !== 1'b0) begin
        bad++;
        $display("FAIL ones_mid_window r%0d: busy=%b valid=%b, required 1 0", r, busy, out_valid);
      end
      drive_beat(1);
      total++;
      if (out_valid !== 1'b1 || data_out !== want[r] || busy !== 1'b0) begin
        bad++;
        $display("FAIL ones_result r%0d: valid=%b data=%h busy=%b, required 1 %h 0",
                 r, out_valid, data_out, busy, want[r]);
      end
      total++;
      if (data_out1 !== want1[r]) begin
        bad++;
        $display("FAIL ones_result_pool1 r%0d: data=%b, required %b", r, data_out1, want1[r]);
      end
    end
    @(posedge clk);
    #1;
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL ones_valid_clear: valid=%b, required 0", out_valid);
    end
  endtask

  task automatic test_mixed();
    for (int b = 0; b < N_BEATS; b++) win_d[b] = rand_beat();
    win_w[0] = {win_d[0], ~win_d[0]};
    win_w[1] = {~win_d[1], ~win_d[1]};
    win_nref = {8'd72, 8'd1};
    win_s    = 2'b01;
    win_pidx = 2'd3;
    send_window(0);
    total++;
    if (out_valid !== 1'b1 || data_out !== 8'h88) begin
      bad++;
      $display("FAIL mixed_result: valid=%b data=%h, required 1 88", out_valid, data_out);
    end
  endtask

  task automatic test_random_back_to_back();
    int start;
    logic [NK*OUT_W-1:0] e0;
    logic [NK-1:0]       e1;
    start = cycle;
    for (int w = 0; w < 24; w++) begin
      randomize_window();
      push_expected();
      send_window(0);
      e0 = exp_q.pop_front();
      e1 = exp1_q.pop_front();
      total++;
      if (out_valid !== 1'b1 || data_out !== e0 || data_out1 !== e1) begin
        bad++;
        $display("FAIL random_w%0d: valid=%b data=%h data1=%b, required 1 %h %b",
                 w, out_valid, data_out, data_out1, e0, e1);
      end
    end
    total++;
    if (cycle - start != 24 * N_BEATS) begin
      bad++;
      $display("FAIL throughput: %0d cycles for 24 windows, required %0d",
               cycle - start, 24 * N_BEATS);
    end
  endtask

  task automatic test_back_pressure();
    logic [NK*OUT_W-1:0] ea, eb;
    out_ready = 1'b1;
    randomize_window();
    push_expected();
    send_window(0);
    ea = exp_q.pop_front();
    void'(exp1_q.pop_front());
    total++;
    if (out_valid !== 1'b1 || data_out !== ea) begin
      bad++;
      $display("FAIL bp_first: valid=%b data=%h, required 1 %h", out_valid, data_out, ea);
    end
    out_ready = 1'b0;
    randomize_window();
    push_expected();
    eb = exp_q.pop_front();
    void'(exp1_q.pop_front());
    set_beat_inputs(0);
    in_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      total++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || data_out !== ea || busy !== 1'b0) begin
        bad++;
        $display("FAIL bp_stall c%0d: ready=%b valid=%b data=%h busy=%b, required 0 1 %h 0",
                 c, in_ready, out_valid, data_out, busy, ea);
      end
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    total++;
    if (out_valid !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL bp_release: valid=%b busy=%b, required 0 1", out_valid, busy);
    end
    drive_beat(1);
    total++;
    if (out_valid !== 1'b1 || data_out !== eb) begin
      bad++;
      $display("FAIL bp_second: valid=%b data=%h, required 1 %h", out_valid, data_out, eb);
    end
  endtask

  task automatic test_reset_mid_window();
    win_d[0] = '1;
    win_w[0] = '1;
    win_nref = {8'd1, 8'd1};
    win_s    = 2'b00;
    win_pidx = 2'd1;
    drive_beat(0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    total++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || data_out !== 8'h00) begin
      bad++;
      $display("FAIL rst_mid_state: busy=%b valid=%b data=%h, required 0 0 00", busy, out_valid, data_out);
    end
    for (int b = 0; b < N_BEATS; b++) begin
      win_d[b] = rand_beat();
      win_w[b] = {~win_d[b], ~win_d[b]};
    end
    send_window(0);
    total++;
    if (out_valid !== 1'b1 || data_out !== 8'h00 || data_out1 !== 2'b00) begin
      bad++;
      $display("FAIL rst_mid_result: valid=%b data=%h data1=%b, required 1 00 00",
               out_valid, data_out, data_out1);
    end
  endtask

  task automatic test_gap();
    logic [NK*OUT_W-1:0] e0, first_res;
    randomize_window();
    push_expected();
    push_expected();
    send_window(0);
    first_res = data_out;
    e0 = exp_q.pop_front();
    void'(exp1_q.pop_front());
    total++;
    if (out_valid !== 1'b1 || data_out !== e0) begin
      bad++;
      $display("FAIL gap_ref: valid=%b data=%h, required 1 %h", out_valid, data_out, e0);
    end
    drive_beat(0);
    for (int g = 0; g < 3; g++) begin
      @(negedge clk);
      total++;
      if (busy !== 1'b1 || out_valid !== 1'b0) begin
        bad++;
        $display("FAIL gap_hold g%0d: busy=%b valid=%b, required 1 0", g, busy, out_valid);
      end
    end
    @(posedge clk);
    #1;
    drive_beat(1);
    e0 = exp_q.pop_front();
    void'(exp1_q.pop_front());
    total++;
    if (out_valid !== 1'b1 || data_out !== e0 || data_out !== first_res) begin
      bad++;
      $display("FAIL gap_result: valid=%b data=%h, required 1 %h", out_valid, data_out, e0);
    end
  endtask

  task automatic test_pool1();
    for (int p = 0; p < 2; p++) begin
      win_d[0] = rand_beat();
      win_w[0] = {win_d[0], win_d[0]};
      win_d[1] = rand_beat();
      win_w[1] = {win_d[1] ^ 36'hFFFF_FFFF0, win_d[1] ^ 36'hFFFF_FFFF0};
      win_nref = {8'd80, 8'd80};
      win_s    = 2'b00;
      win_pidx = 2'd3;
      pindex1  = 1'(p);
      send_window(0);
      total++;
      if (out_valid1 !== 1'b1 || data_out1 !== 2'b11) begin
        bad++;
        $display("FAIL pool1_result p%0d: valid=%b data=%b, required 1 11", p, out_valid1, data_out1);
      end
      total++;
      if (data_out !== 8'h88) begin
        bad++;
        $display("FAIL pool1_pool2_ref p%0d: data=%h, required 88", p, data_out);
      end
    end
  endtask

  initial begin
    test_reset();
    test_all_ones();
    test_mixed();
    test_random_back_to_back();
    test_back_pressure();
    test_reset_mid_window();
    test_gap();
    test_pool1();
    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
